// File: rtl/apb_to_axi4lite_master.sv
// APB4 completer that turns each APB transfer into one AXI4-Lite write or read.
// The APB access phase is stretched (pready low) until the AXI response returns.
module apb_to_axi4lite_master #(
   parameter int dataWidth = 32,
   parameter int addrWidth = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   psel,
   input  logic                   penable,
   input  logic                   pwrite,
   input  logic [addrWidth-1:0]   paddr,
   input  logic [dataWidth-1:0]   pwdata,
   input  logic [dataWidth/8-1:0] pstrb,
   input  logic [2:0]             pprot,
   output logic                   pready,
   output logic [dataWidth-1:0]   prdata,
   output logic                   pslverr,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [addrWidth-1:0]   awaddr,
   output logic [2:0]             awprot,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [dataWidth-1:0]   wdata,
   output logic [dataWidth/8-1:0] wstrb,
   input  logic                   bvalid,
   output logic                   bready,
   input  logic [1:0]             bresp,
   output logic                   arvalid,
   input  logic                   arready,
   output logic [addrWidth-1:0]   araddr,
   output logic [2:0]             arprot,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [dataWidth-1:0]   rdata,
   input  logic [1:0]             rresp
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t                 r_state,   w_state;
   logic                   r_awvalid, w_awvalid;
   logic                   r_wvalid,  w_wvalid;
   logic                   r_bready,  w_bready;
   logic                   r_arvalid, w_arvalid;
   logic                   r_rready,  w_rready;
   logic                   r_pready,  w_pready;
   logic                   r_pslverr, w_pslverr;
   logic [dataWidth-1:0]   r_prdata,  w_prdata;
   logic [addrWidth-1:0]   r_awaddr,  w_awaddr;
   logic [2:0]             r_awprot,  w_awprot;
   logic [dataWidth-1:0]   r_wdata,   w_wdata;
   logic [dataWidth/8-1:0] r_wstrb,   w_wstrb;
   logic [addrWidth-1:0]   r_araddr,  w_araddr;
   logic [2:0]             r_arprot,  w_arprot;

   // SLVERR (2'b10) and DECERR (2'b11) map to an APB error; OKAY/EXOKAY do not.
   function automatic logic resp_is_err(input logic [1:0] resp);
      return (resp == 2'b10) || (resp == 2'b11);
   endfunction

   always_comb begin
      w_state   = r_state;
      w_awvalid = r_awvalid;
      w_wvalid  = r_wvalid;
      w_bready  = r_bready;
      w_arvalid = r_arvalid;
      w_rready  = r_rready;
      w_pready  = r_pready;
      w_pslverr = r_pslverr;
      w_prdata  = r_prdata;
      w_awaddr  = r_awaddr;
      w_awprot  = r_awprot;
      w_wdata   = r_wdata;
      w_wstrb   = r_wstrb;
      w_araddr  = r_araddr;
      w_arprot  = r_arprot;

      case (r_state)
         IDLE: begin
            // Only a setup phase starts a transfer; a stray access phase is ignored.
            if (psel && !penable) begin
               if (pwrite) begin
                  w_awaddr  = paddr;
                  w_awprot  = pprot;
                  w_wdata   = pwdata;
                  w_wstrb   = pstrb;
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
                  w_state   = WR_REQ;
               end else begin
                  w_araddr  = paddr;
                  w_arprot  = pprot;
                  w_arvalid = 1'b1;
                  w_state   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            w_awvalid = r_awvalid & ~awready;
            w_wvalid  = r_wvalid  & ~wready;
            if (!w_awvalid && !w_wvalid) begin
               w_bready = 1'b1;
               w_state  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               w_bready  = 1'b0;
               w_pslverr = resp_is_err(bresp);
               w_pready  = 1'b1;
               w_state   = DONE;
            end
         end
         RD_REQ: begin
            if (arready) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (rvalid) begin
               w_rready  = 1'b0;
               w_prdata  = rdata;
               w_pslverr = resp_is_err(rresp);
               w_pready  = 1'b1;
               w_state   = DONE;
            end
         end
         DONE: begin
            w_pready  = 1'b0;
            w_pslverr = 1'b0;
            w_state   = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_bready  <= 1'b0;
         r_arvalid <= 1'b0;
         r_rready  <= 1'b0;
         r_pready  <= 1'b0;
         r_pslverr <= 1'b0;
         r_prdata  <= '0;
         r_awaddr  <= '0;
         r_awprot  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_araddr  <= '0;
         r_arprot  <= '0;
      end else begin
         r_state   <= w_state;
         r_awvalid <= w_awvalid;
         r_wvalid  <= w_wvalid;
         r_bready  <= w_bready;
         r_arvalid <= w_arvalid;
         r_rready  <= w_rready;
         r_pready  <= w_pready;
         r_pslverr <= w_pslverr;
         r_prdata  <= w_prdata;
         r_awaddr  <= w_awaddr;
         r_awprot  <= w_awprot;
         r_wdata   <= w_wdata;
         r_wstrb   <= w_wstrb;
         r_araddr  <= w_araddr;
         r_arprot  <= w_arprot;
      end
   end

   assign pready  = r_pready;
   assign prdata  = r_prdata;
   assign pslverr = r_pslverr;
   assign awvalid = r_awvalid;
   assign awaddr  = r_awaddr;
   assign awprot  = r_awprot;
   assign wvalid  = r_wvalid;
   assign wdata   = r_wdata;
   assign wstrb   = r_wstrb;
   assign bready  = r_bready;
   assign arvalid = r_arvalid;
   assign araddr  = r_araddr;
   assign arprot  = r_arprot;
   assign rready  = r_rready;

endmodule

// File: tb/tb_apb_to_axi4lite_master.sv
// Directed bench for apb_to_axi4lite_master: an APB requester task, a delay-configurable
// AXI4-Lite subordinate model, a vector table and a few hand-written corner sequences.
module tb_apb_to_axi4lite_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [2:0]  pprot = '0;
   logic        pready, pslverr;
   logic [31:0] prdata;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp = '0, rresp = '0;
   logic [31:0] rdata_i = '0;

   apb_to_axi4lite_master #(.dataWidth(32), .addrWidth(32)) dut (
      .clk(clk), .rst(rst),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
      .pready(pready), .prdata(prdata), .pslverr(pslverr),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
      .rvalid(rvalid), .rready(rready), .rdata(rdata_i), .rresp(rresp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [31:0] wdat;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
      logic [1:0]  resp;
      logic [31:0] rdat;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_prdata;
      int          exp_avc;   // awvalid cycles (write) or arvalid cycles (read)
      int          exp_wvc;
   } vec_t;

   int tests = 0, fails = 0;

   // subordinate configuration, written only by the stimulus process
   int         cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_b = 0, cfg_r = 0;
   logic [1:0]  cfg_resp = '0;
   logic [31:0] cfg_rdata = '0;

   // subordinate model state, written only by the monitor process
   int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
   int awv_cyc = 0, wv_cyc = 0, arv_cyc = 0;
   int aw_hs = 0, w_hs = 0, ar_hs = 0;
   int overlap = 0, ordr_err = 0, stab_err = 0;
   logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
   logic [3:0]  cap_wstrb = '0;
   logic [2:0]  cap_awprot = '0, cap_arprot = '0;
   logic [31:0] prev_awaddr = '0, prev_wdata = '0, prev_araddr = '0;

   // Readies/valids change on the falling edge so the DUT sees them stable at the rising edge.
   always @(negedge clk) begin
      if (awvalid) begin
         if (aw_cnt > 0 && awaddr !== prev_awaddr) stab_err++;
         prev_awaddr = awaddr;
         awready = (aw_cnt >= cfg_aw);
         if (awready) begin cap_awaddr = awaddr; cap_awprot = awprot; aw_hs++; end
         aw_cnt++; awv_cyc++;
      end else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin
         if (w_cnt > 0 && wdata !== prev_wdata) stab_err++;
         prev_wdata = wdata;
         wready = (w_cnt >= cfg_w);
         if (wready) begin cap_wdata = wdata; cap_wstrb = wstrb; w_hs++; end
         w_cnt++; wv_cyc++;
      end else begin wready = 1'b0; w_cnt = 0; end
      if (arvalid) begin
         if (ar_cnt > 0 && araddr !== prev_araddr) stab_err++;
         prev_araddr = araddr;
         arready = (ar_cnt >= cfg_ar);
         if (arready) begin cap_araddr = araddr; cap_arprot = arprot; ar_hs++; end
         ar_cnt++; arv_cyc++;
      end else begin arready = 1'b0; ar_cnt = 0; end
      if (bready) begin
         bvalid = (b_cnt >= cfg_b);
         bresp  = bvalid ? cfg_resp : 2'b00;
         b_cnt++;
      end else begin bvalid = 1'b0; bresp = 2'b00; b_cnt = 0; end
      if (rready) begin
         rvalid  = (r_cnt >= cfg_r);
         rresp   = rvalid ? cfg_resp : 2'b00;
         rdata_i = rvalid ? cfg_rdata : 32'h0;
         r_cnt++;
      end else begin rvalid = 1'b0; rresp = 2'b00; rdata_i = '0; r_cnt = 0; end
      if (awvalid && arvalid) overlap++;
      if (bready && (awvalid || wvalid)) ordr_err++;
      if (rready && arvalid) ordr_err++;
      if ((bready || rready) && pready) ordr_err++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One APB transfer starting right now (just after a rising edge) with the setup phase.
   task automatic apb_xfer(input vec_t v, output int lat, output logic [31:0] rd,
                           output logic err, output logic post_rdy, output logic post_err);
      cfg_aw = v.aw_dly; cfg_w = v.w_dly; cfg_ar = v.ar_dly;
      cfg_b = v.b_dly; cfg_r = v.r_dly; cfg_resp = v.resp; cfg_rdata = v.rdat;
      psel = 1'b1; penable = 1'b0; pwrite = v.w; paddr = v.addr;
      pwdata = v.wdat; pstrb = v.strb; pprot = v.prot;
      @(posedge clk); #1;
      penable = 1'b1;
      lat = 1;
      while (!pready && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      rd  = prdata;
      err = pslverr;
      @(posedge clk); #1;
      post_rdy = pready;
      post_err = pslverr;
      psel = 1'b0; penable = 1'b0;
   endtask

   vec_t        vecs[7];
   vec_t        v2;
   int          lat, s_awv, s_wv, s_arv, s_aw, s_ar;
   logic [31:0] rd;
   logic        err, prdy, perr;

   initial begin
      //           w     addr    wdat          strb  prot aw w ar b r resp   rdat          lat err  prdata        avc wvc
      vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        3, 1'b0, 32'h0,        1, 1};
      vecs[1] = '{1'b1, 32'h14, 32'h01020304, 4'hF, 3'd1, 3, 0, 0, 0, 0, 2'b00, 32'h0,        6, 1'b0, 32'h0,        4, 1};
      vecs[2] = '{1'b0, 32'h20, 32'h0,        4'h0, 3'd2, 0, 0, 0, 0, 2, 2'b10, 32'h12345678, 5, 1'b1, 32'h12345678, 1, 0};
      vecs[3] = '{1'b1, 32'h30, 32'hA0B0C0D0, 4'hC, 3'd0, 0, 0, 0, 5, 0, 2'b11, 32'h0,        8, 1'b1, 32'h12345678, 1, 1};
      vecs[4] = '{1'b0, 32'h40, 32'h0,        4'h0, 3'd6, 0, 0, 1, 0, 0, 2'b01, 32'hA5A50000, 4, 1'b0, 32'hA5A50000, 2, 0};
      vecs[5] = '{1'b1, 32'h44, 32'h55AA55AA, 4'h3, 3'd5, 0, 2, 0, 0, 0, 2'b00, 32'h0,        5, 1'b0, 32'hA5A50000, 1, 3};
      vecs[6] = '{1'b1, 32'h48, 32'h0BADF00D, 4'h1, 3'd3, 2, 1, 0, 0, 0, 2'b01, 32'h0,        5, 1'b0, 32'hA5A50000, 3, 2};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_ctrl", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
      chk("rst_pready", {31'd0, pready}, 32'h0);
      chk("rst_pslverr", {31'd0, pslverr}, 32'h0);
      chk("rst_prdata", prdata, 32'h0);
      chk("rst_addr", awaddr | araddr, 32'h0);
      chk("rst_wdata", {wdata[31:4], wdata[3:0] | wstrb}, 32'h0);
      chk("rst_prot", {26'd0, awprot, arprot}, 32'h0);

      // access phase without setup while idle: no AXI activity
      s_awv = awv_cyc; s_arv = arv_cyc;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h99;
      repeat (4) @(posedge clk);
      #1;
      chk("viol_aw", awv_cyc - s_awv, 0);
      chk("viol_ar", arv_cyc - s_arv, 0);
      chk("viol_pready", {31'd0, pready}, 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         s_awv = awv_cyc; s_wv = wv_cyc; s_arv = arv_cyc;
         apb_xfer(vecs[i], lat, rd, err, prdy, perr);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
         chk($sformatf("v%0d_pslverr", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_prdata);
         chk($sformatf("v%0d_post_pready", i), {31'd0, prdy}, 32'h0);
         chk($sformatf("v%0d_post_pslverr", i), {31'd0, perr}, 32'h0);
         if (vecs[i].w) begin
            chk($sformatf("v%0d_awvalid_cyc", i), awv_cyc - s_awv, vecs[i].exp_avc);
            chk($sformatf("v%0d_wvalid_cyc", i), wv_cyc - s_wv, vecs[i].exp_wvc);
            chk($sformatf("v%0d_awaddr", i), cap_awaddr, vecs[i].addr);
            chk($sformatf("v%0d_wdata", i), cap_wdata, vecs[i].wdat);
            chk($sformatf("v%0d_wstrb", i), {28'd0, cap_wstrb}, {28'd0, vecs[i].strb});
            chk($sformatf("v%0d_awprot", i), {29'd0, cap_awprot}, {29'd0, vecs[i].prot});
         end else begin
            chk($sformatf("v%0d_arvalid_cyc", i), arv_cyc - s_arv, vecs[i].exp_avc);
            chk($sformatf("v%0d_araddr", i), cap_araddr, vecs[i].addr);
            chk($sformatf("v%0d_arprot", i), {29'd0, cap_arprot}, {29'd0, vecs[i].prot});
         end
         @(posedge clk); #1;
      end

      // back-to-back write then read with no idle gap between transfers
      s_aw = aw_hs; s_ar = ar_hs;
      vecs[0] = '{1'b1, 32'h60, 32'h11112222, 4'hF, 3'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        3, 1'b0, 32'hA5A50000, 1, 1};
      v2      = '{1'b0, 32'h64, 32'h0,        4'h0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFEF00D, 3, 1'b0, 32'hCAFEF00D, 1, 0};
      apb_xfer(vecs[0], lat, rd, err, prdy, perr);
      chk("b2b_wr_latency", lat, 3);
      chk("b2b_awaddr", cap_awaddr, 32'h60);
      apb_xfer(v2, lat, rd, err, prdy, perr);
      chk("b2b_rd_latency", lat, 3);
      chk("b2b_prdata", rd, 32'hCAFEF00D);
      chk("b2b_araddr", cap_araddr, 32'h64);
      chk("b2b_aw_count", aw_hs - s_aw, 1);
      chk("b2b_ar_count", ar_hs - s_ar, 1);
      @(posedge clk); #1;

      // reset while a write waits on awready
      cfg_aw = 50; cfg_w = 0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50; pwdata = 32'h77; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      chk("mid_awvalid", {31'd0, awvalid}, 32'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      chk("mid_rst_ctrl", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
      chk("mid_rst_pready", {31'd0, pready}, 32'h0);
      @(posedge clk); #1;
      v2 = '{1'b0, 32'h70, 32'h0, 4'h0, 3'd0, 0, 0, 0, 0, 0, 2'b00, 32'h600DCAFE, 3, 1'b0, 32'h600DCAFE, 1, 0};
      apb_xfer(v2, lat, rd, err, prdy, perr);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_prdata", rd, 32'h600DCAFE);
      chk("post_rst_pslverr", {31'd0, err}, 32'h0);

      // protocol monitors accumulated over the whole run
      chk("aw_ar_overlap", overlap, 0);
      chk("ready_order", ordr_err, 0);
      chk("payload_stable", stab_err, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_to_axi4lite_master.md
Name: apb_to_axi4lite_master

Overview:
- APB4 completer in front of an AXI4-Lite manager. Each APB transfer becomes exactly one AXI4-Lite write (AW+W+B) or read (AR+R).
- Sits at the bridge boundary in the opposite direction to the AXI4-Lite-to-APB path. An APB requester reaches AXI4-Lite subordinates through it.
- APB is held in the access phase (pready low) until the AXI response has been received.

Parameters:
- dataWidth, 32, data bus width for APB and AXI; multiple of 8.
- addrWidth, 32, address width for APB and AXI.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- psel  input  1  APB select.
- penable  input  1  APB enable (access phase).
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  addrWidth  APB address.
- pwdata  input  dataWidth  APB write data.
- pstrb  input  dataWidth/8  APB write strobes.
- pprot  input  3  APB protection.
- pready  output  1  transfer complete.
- prdata  output  dataWidth  read data.
- pslverr  output  1  transfer error.
- awvalid, awready  output, input  1, 1  AXI write-address handshake.
- awaddr, awprot  output  addrWidth, 3  AXI write address and protection.
- wvalid, wready  output, input  1, 1  AXI write-data handshake.
- wdata, wstrb  output  dataWidth, dataWidth/8  AXI write data and strobes.
- bvalid, bready  input, output  1, 1  AXI write-response handshake.
- bresp  input  2  AXI write response.
- arvalid, arready  output, input  1, 1  AXI read-address handshake.
- araddr, arprot  output  addrWidth, 3  AXI read address and protection.
- rvalid, rready  input, output  1, 1  AXI read-data handshake.
- rdata  input  dataWidth  AXI read data.
- rresp  input  2  AXI read response.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - All valid/ready outputs = 0, pready = 0, pslverr = 0.
  - prdata, awaddr, araddr, wdata, wstrb, awprot, arprot = 0.
  - Reset mid-transaction abandons the AXI transfer immediately; no completion is issued.
- All outputs are registered. States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
- IDLE:
  - Start condition is psel=1 and penable=0 (setup phase).
  - Write start: capture awaddr=paddr, awprot=pprot, wdata=pwdata, wstrb=pstrb; set awvalid=1, wvalid=1; go to WR_REQ.
  - Read start: capture araddr=paddr, arprot=pprot; set arvalid=1; go to RD_REQ.
  - psel=1 with penable=1 while in IDLE is ignored (protocol violation; no AXI activity).
- WR_REQ:
  - awvalid stays high until a cycle with awvalid&awready, then drops. wvalid is handled the same way with wready, independently.
  - awaddr, awprot, wdata, wstrb are stable while their valid is high.
  - Move to WR_RESP with bready=1 in the cycle after both handshakes have completed, whether they occur in the same or different cycles.
- WR_RESP:
  - bready held at 1.
  - On bvalid&bready: bready=0, pslverr=bresp[1], prdata unchanged; go to DONE.
- RD_REQ:
  - arvalid held until arvalid&arready; then arvalid=0, rready=1; go to RD_RESP.
- RD_RESP:
  - rready held at 1.
  - On rvalid&rready: rready=0, prdata=rdata, pslverr=rresp[1]; go to DONE.
- DONE:
  - pready=1 for exactly one cycle (APB access cycle completes).
  - Next cycle: pready=0, pslverr=0, state=IDLE.
  - prdata holds its value until the next read completes.
- bready and rready are never 1 outside WR_RESP / RD_RESP.
- Response decoding: OKAY and EXOKAY give pslverr=0; SLVERR and DECERR give pslverr=1.
- Minimum latency, all AXI readies/valids immediate:
  - setup cycle T0;
  - valids high T1;
  - bready/rready high T2;
  - pready high T3.
- Back-to-back: a new setup phase can be accepted the cycle after DONE, i.e. in IDLE.
- No transaction IDs and no outstanding overlap: only one AXI transaction in flight.

Test Plan:
- Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF, AXI readies always 1, bresp=OKAY at first bready -> awaddr=0x10, wdata=0xDEADBEEF for exactly 1 cycle; pready=1 three cycles after setup; pslverr=0.
- Write with awready delayed 3 cycles, wready=1 immediately -> wvalid drops after 1 cycle; awvalid high 4 cycles with awaddr stable; bready asserted only after the AW handshake.
- Read paddr=0x20, rvalid after 2 stall cycles with rdata=0x12345678, rresp=SLVERR -> prdata=0x12345678, pslverr=1 during the single pready cycle; pslverr=0 the next cycle.
- Write with bvalid stalled 5 cycles, bresp=DECERR -> pready stays 0 throughout the stall, then 1 for one cycle with pslverr=1.
- Back-to-back write then read (psel kept 1, new setup right after pready) -> two distinct AXI transactions; araddr equals the second paddr; no overlap of awvalid and arvalid.
- rst=1 while in WR_REQ with awvalid=1 -> next cycle all valids/readies=0, pready=0; a subsequent read completes normally.
